// File: rtl/sram22_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram22_req_ctrl : valid/ready request front-end for one sram22 macro, with a
// credit-protected in-order read response FIFO. Optional zero-fill on reset
// when SRAM22_CTRL_INIT_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram22_req_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WMASK_WIDTH = 2,
  parameter int RSP_DEPTH   = 3
) (
  input  logic                   clk_i,
  input  logic                   rstb_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [WMASK_WIDTH-1:0] req_wmask_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [DATA_WIDTH-1:0]  req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
  output logic                   sram_ce_o,
  output logic                   sram_we_o,
  output logic [WMASK_WIDTH-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0]  sram_addr_o,
  output logic [DATA_WIDTH-1:0]  sram_din_o,
  input  logic [DATA_WIDTH-1:0]  sram_dout_i,
  output logic                   init_busy_o
);

  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int c_CRD_W = c_OCC_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RSP_DEPTH - 1);
  localparam logic [c_OCC_W-1:0] c_OCC_FULL = c_OCC_W'(RSP_DEPTH);
  localparam logic [c_CRD_W-1:0] c_CREDITS  = c_CRD_W'(RSP_DEPTH);

  logic                  w_run;
  logic                  w_init;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_fire;
  logic                  w_push;
  logic                  w_pop;
  logic [c_CRD_W-1:0]    w_credit_used;

  logic                  rd_pend_q, rd_pend_d;
  logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_OCC_W-1:0]    occ_q, occ_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

`ifdef SRAM22_CTRL_INIT_EN
  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == c_ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_WIDTH'(1);
      if (init_addr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = c_ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      state_q     <= c_ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  assign w_run       = rstb_i && (state_q == c_ST_RUN);
  assign w_init      = rstb_i && (state_q == c_ST_INIT);
  assign w_init_addr = init_addr_q;
`else
  assign w_run       = rstb_i;
  assign w_init      = 1'b0;
  assign w_init_addr = '0;
`endif

  // Credits count both buffered responses and the read whose dout is due now.
  assign w_credit_used = c_CRD_W'(occ_q) + c_CRD_W'(rd_pend_q);
  assign req_ready_o   = w_run && (w_credit_used < c_CREDITS);
  assign w_fire        = req_valid_i && req_ready_o;
  assign init_busy_o   = w_init;

  always_comb begin
    if (w_init) begin
      sram_ce_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_wmask_o = {WMASK_WIDTH{1'b1}};
      sram_addr_o  = w_init_addr;
      sram_din_o   = '0;
    end else begin
      sram_ce_o    = w_fire;
      sram_we_o    = req_we_i;
      sram_wmask_o = req_wmask_i;
      sram_addr_o  = req_addr_i;
      sram_din_o   = req_wdata_i;
    end
  end

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_push      = rstb_i && rd_pend_q;
  assign rsp_valid_o = rstb_i && (occ_q != '0);
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = fifo_q[rd_ptr_q];
  assign rd_pend_d   = w_fire && !req_we_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (w_push && !w_pop) begin
      occ_d = occ_q + c_OCC_W'(1);
    end else if (!w_push && w_pop) begin
      occ_d = occ_q - c_OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      assert (!(w_push && !w_pop && (occ_q == c_OCC_FULL)));
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= sram_dout_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram22_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram22_req_ctrl : directed plus randomized bench for sram22_req_ctrl with
// a behavioural macro and a transaction-level reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram22_req_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int DEPTH = 3;
  localparam int NWORDS = 256;
`ifdef SRAM22_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb, req_valid, req_we, rsp_ready;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, sram_ce, sram_we, init_busy;
  logic [DW-1:0] rsp_rdata, sram_din, sram_dout;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;

  sram22_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstb_i(rstb),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_wmask_i(req_wmask), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_wmask_o(sram_wmask),
    .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_dout_i(sram_dout),
    .init_busy_o(init_busy)
  );

  // Power-up macro contents: an address-dependent pattern (stored XOR pattern).
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return ({8'h00, a} * 16'h9E37) ^ 16'h5A3C;
  endfunction

  bit   [DW-1:0] mac_mem [NWORDS];
  logic [DW-1:0] mac_pat;
  assign mac_pat = pat(sram_addr);

  always @(posedge clk) begin
    if (sram_ce === 1'b1) begin
      if (sram_we) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l]) mac_mem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8] ^ mac_pat[8*l +: 8];
      end else begin
        sram_dout <= mac_mem[sram_addr] ^ mac_pat;
      end
    end
  end

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NWORDS];
  int            cyc, tests, fails, m_init_addr;
  bit            m_run;
  bit            last_fire, last_pop, last_ready, last_valid, last_init;
  logic [DW-1:0] last_pop_data, d;
  int            n, k, fires, pops, lat, fire_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: inputs are already applied; sample, compare, advance the model.
  task automatic do_cycle();
    bit exp_ready, exp_valid, exp_ce, fire_m;
    #1;
    exp_ready = rstb && m_run && (exp_q.size() < DEPTH);
    exp_valid = rstb && (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
    fire_m    = exp_ready && req_valid;
    exp_ce    = rstb && (m_run ? fire_m : 1'b1);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("init_busy", 32'(init_busy), 32'(rstb && !m_run));
    check("sram_ce", 32'(sram_ce), 32'(exp_ce));
    if (exp_ce && !m_run)
      check("init_pins", 32'({sram_we, sram_wmask, sram_addr, sram_din}),
            32'({1'b1, 2'b11, AW'(m_init_addr), 16'h0000}));
    else if (fire_m)
      check("sram_pins", 32'({sram_we, sram_wmask, sram_addr, sram_din}),
            32'({req_we, req_wmask, req_addr, req_wdata}));
    if (exp_valid) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].data));
    last_fire = (req_valid === 1'b1) && (req_ready === 1'b1);
    last_pop  = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
    last_ready = (req_ready === 1'b1);
    last_valid = (rsp_valid === 1'b1);
    last_init  = (init_busy === 1'b1);
    last_pop_data = rsp_rdata;
    if (!rstb) begin
      exp_q.delete();
      m_run = !INIT_EN;
      m_init_addr = 0;
    end else begin
      if (exp_valid && rsp_ready) void'(exp_q.pop_front());
      if (!m_run) begin
        ref_mem[m_init_addr] = '0;
        if (m_init_addr == NWORDS - 1) m_run = 1'b1;
        m_init_addr++;
      end else if (fire_m) begin
        if (req_we) begin
          for (int l = 0; l < MW; l++)
            if (req_wmask[l]) ref_mem[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
        end else begin
          exp_q.push_back('{data: ref_mem[req_addr], cyc: cyc});
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input bit we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      do_cycle();
      if (last_fire) break;
    end
    check("issue_fired", 32'(last_fire), 32'd1);
    fire_cyc  = cyc - 1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [DW-1:0] data, output int latency);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      if (last_pop) break;
    end
    check("rsp_seen", 32'(last_pop), 32'd1);
    data    = last_pop_data;
    latency = (cyc - 1) - fire_cyc;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; m_init_addr = 0; m_run = !INIT_EN;
    for (int a = 0; a < NWORDS; a++) ref_mem[a] = pat(AW'(a));
    rstb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) do_cycle();
    rstb = 1'b1;

    // Zero-fill length (0 cycles when the fill is not built in)
    n = 0;
    for (int i = 0; i < 300; i++) begin
      do_cycle();
      if (last_init) n++;
      else break;
    end
    check("init_len", 32'(n), INIT_EN ? 32'd256 : 32'd0);
    check("ready_after_init", 32'(last_ready), 32'd1);
    issue(1'b0, 2'b00, 8'hFF, '0);
    get_rsp(d, lat);
    check("rd_ff", 32'(d), INIT_EN ? 32'h0000 : 32'(pat(8'hFF)));

    // Full write, read back, then lane-0 partial write
    issue(1'b1, 2'b11, 8'h12, 16'hBEEF);
    issue(1'b0, 2'b00, 8'h12, '0);
    get_rsp(d, lat);
    check("rd_beef_lat", 32'(lat), 32'd2);
    check("rd_beef", 32'(d), 32'hBEEF);
    issue(1'b1, 2'b01, 8'h12, 16'h00AA);
    issue(1'b0, 2'b00, 8'h12, '0);
    get_rsp(d, lat);
    check("rd_beaa_lat", 32'(lat), 32'd2);
    check("rd_beaa", 32'(d), 32'hBEAA);

    // Backpressure: five reads with the consumer stalled
    for (int i = 0; i < 5; i++) issue(1'b1, 2'b11, AW'(8'h10 + i), DW'(16'hC000 + 16'h0111 * i));
    rsp_ready = 1'b0; k = 0; pops = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (k < 5); req_we = 1'b0; req_addr = AW'(8'h10 + k);
      do_cycle();
      if (last_fire) k++;
      if (last_pop) pops++;
    end
    check("bp_fires", 32'(k), 32'd3);
    check("bp_ready_low", 32'(last_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_valid = (k < 5); req_addr = AW'(8'h10 + k);
      do_cycle();
      if (last_fire) k++;
      if (last_pop) pops++;
    end
    check("bp_all_fired", 32'(k), 32'd5);
    check("bp_pops", 32'(pops), 32'd5);

    // Streaming: one read per cycle
    fires = 0; pops = 0;
    for (int i = 0; i < 66; i++) begin
      req_valid = (i < 64); req_we = 1'b0; req_addr = AW'($urandom_range(0, 255));
      do_cycle();
      if (last_fire) fires++;
      if (last_pop) pops++;
    end
    check("stream_fires", 32'(fires), 32'd64);
    check("stream_pops", 32'(pops), 32'd64);

    // Random mixed traffic on a small address window
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_wmask = MW'($urandom_range(0, 3));
      req_addr  = AW'($urandom_range(32, 39));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      do_cycle();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) do_cycle();

    // Reset with two reads in flight
    rsp_ready = 1'b0;
    issue(1'b0, 2'b00, 8'h21, '0);
    issue(1'b0, 2'b00, 8'h22, '0);
    rstb = 1'b0;
    do_cycle();
    check("rst_rsp_valid", 32'(last_valid), 32'd0);
    rstb = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_cycle();
      if (!last_init) break;
    end
    check("reinit_done", 32'(last_init), 32'd0);
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      if (last_pop) pops++;
    end
    check("no_stale_rsp", 32'(pops), 32'd0);
    issue(1'b1, 2'b11, 8'h33, 16'h5A5A);
    issue(1'b0, 2'b00, 8'h33, '0);
    get_rsp(d, lat);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_rd", 32'(d), 32'h5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
